fp_add_result_stage: RTL and testbench

- Registered output stage directly downstream of the half-precision fp_adder_subtractor.
- Captures the combinational result word and its status flags into a 2-entry skid buffer with a valid/ready handshake, giving the adder a clean registered boundary to the ALU writeback path.
- Keeps sticky exception flags (overflow, inf, nan, subnormal) and a saturating count of accepted operations for the status/CPSR logic.

---
 rtl/fp_add_result_stage.sv | 120 ++++++++++++
 tb/tb_fp_add_result_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_result_stage.sv
// rtl/fp_add_result_stage.sv - registered 2-entry skid output stage for the fp16 adder
module fp_add_result_stage #(
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_r,
  input  logic [5:0]         in_flags,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_r,
  output logic [5:0]         out_flags,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               sticky_clr,
  output logic [3:0]         sticky_flags,
  output logic [COUNT_W-1:0] op_count
);

  // A stored word is {tag, r, flags}; flags sit in the low bits.
  localparam int WORD_W = TAG_W + 16 + 6;

  logic              skid_valid;
  logic [WORD_W-1:0] main_word;
  logic [WORD_W-1:0] skid_word;
  logic [WORD_W-1:0] in_word;
  logic              accept;
  logic              pop;
  logic              main_load_in;
  logic              main_load_skid;
  logic              skid_load;

  // Ready depends only on registered state so the adder sees no comb path from out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign in_word  = {in_tag, in_r, in_flags};

  assign out_flags = main_word[5:0];
  assign out_r     = main_word[21:6];
  assign out_tag   = main_word[WORD_W-1:22];

  // Load decisions: input goes to main when main is free or draining, otherwise to skid.
  always_comb begin
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (!skid_valid) begin
      if (accept && (!out_valid || pop)) begin
        main_load_in = 1'b1;
      end else if (accept) begin
        skid_load = 1'b1;
      end
    end else if (pop) begin
      main_load_skid = 1'b1;
    end
  end

  // Main entry valid bit and skid valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load_in) begin
        out_valid <= 1'b1;
      end else if (skid_load || main_load_skid) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (skid_load) begin
        skid_valid <= 1'b1;
      end else if (main_load_skid) begin
        skid_valid <= 1'b0;
      end
    end
  end

  // Data registers change only on a load, keeping outputs stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_word <= '0;
      skid_word <= '0;
    end else begin
      if (main_load_in) begin
        main_word <= in_word;
      end else if (main_load_skid) begin
        main_word <= skid_word;
      end
      if (skid_load) begin
        skid_word <= in_word;
      end
    end
  end

  // Sticky exception flags; an accept in the clear cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 4'b0000;
    end else if (sticky_clr) begin
      sticky_flags <= accept ? in_flags[3:0] : 4'b0000;
    end else if (accept) begin
      sticky_flags <= sticky_flags | in_flags[3:0];
    end
  end

  // Saturating accepted-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept && (op_count != {COUNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_result_stage.sv
// tb/tb_fp_add_result_stage.sv - directed self-checking bench for fp_add_result_stage
module tb_fp_add_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_r;
  logic [5:0]  in_flags;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic [5:0]  out_flags;
  logic [3:0]  out_tag;
  logic        sticky_clr;
  logic [3:0]  sticky_flags;
  logic [7:0]  op_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_r;
  logic [5:0]  s_out_flags;
  logic [3:0]  s_out_tag;
  logic [3:0]  s_sticky_flags;
  logic [3:0]  s_op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_add_result_stage #(.TAG_W(4), .COUNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_flags(out_flags), .out_tag(out_tag), .sticky_clr(sticky_clr),
    .sticky_flags(sticky_flags), .op_count(op_count)
  );

  fp_add_result_stage #(.TAG_W(4), .COUNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_r(in_r), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_r(s_out_r),
    .out_flags(s_out_flags), .out_tag(s_out_tag), .sticky_clr(sticky_clr),
    .sticky_flags(s_sticky_flags), .op_count(s_op_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_flags = '0; in_tag = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    #3;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_r", out_r, 0);
    check_eq("rst_sticky", sticky_flags, 0);
    check_eq("rst_count", op_count, 0);
    step(); step();
    rst = 1'b0;

    // single transfer
    in_valid = 1; in_r = 16'h3C00; in_flags = 6'b000000; in_tag = 4'd1; out_ready = 1;
    step();
    check_eq("single_valid", out_valid, 1);
    check_eq("single_r", out_r, 16'h3C00);
    check_eq("single_tag", out_tag, 1);
    check_eq("single_count", op_count, 1);
    in_valid = 0;
    step();
    check_eq("single_drain", out_valid, 0);

    // backpressure
    out_ready = 0; in_valid = 1; in_r = 16'h3C00; in_tag = 4'd2;
    step();
    check_eq("bp_ready1", in_ready, 1);
    check_eq("bp_main1", out_r, 16'h3C00);
    in_r = 16'h4000; in_tag = 4'd3;
    step();
    check_eq("bp_ready2", in_ready, 0);
    check_eq("bp_main2", out_r, 16'h3C00);
    in_r = 16'h4200; in_tag = 4'd4;
    step();
    check_eq("bp_ready3", in_ready, 0);
    check_eq("bp_hold_r", out_r, 16'h3C00);
    check_eq("bp_hold_tag", out_tag, 2);
    out_ready = 1;
    step();
    check_eq("bp_out2", out_r, 16'h4000);
    check_eq("bp_out2_tag", out_tag, 3);
    check_eq("bp_ready4", in_ready, 1);
    step();
    check_eq("bp_out3", out_r, 16'h4200);
    check_eq("bp_out3_tag", out_tag, 4);
    check_eq("bp_count", op_count, 4);
    in_valid = 0;
    step();
    check_eq("bp_drain", out_valid, 0);

    // sticky accumulation and clear
    in_valid = 1; in_r = 16'h7C00; in_flags = 6'b001100; in_tag = 4'd7;
    step();
    check_eq("st_first", sticky_flags, 4'b1100);
    in_r = 16'h0001; in_flags = 6'b000001;
    step();
    check_eq("st_accum", sticky_flags, 4'b1101);
    sticky_clr = 1; in_r = 16'h7FFF; in_flags = 6'b000010;
    step();
    check_eq("st_clr_accept", sticky_flags, 4'b0010);
    check_eq("st_out_r", out_r, 16'h7FFF);
    check_eq("st_out_flags", out_flags, 6'b000010);
    in_valid = 0;
    step();
    check_eq("st_clr_idle", sticky_flags, 0);
    sticky_clr = 0;
    check_eq("st_count", op_count, 7);

    // full throughput
    in_valid = 1; in_flags = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      in_r = 16'h3C00 + 16'(i); in_tag = 4'(i);
      step();
      check_eq("tp_valid", out_valid, 1);
      check_eq("tp_r", out_r, 16'h3C00 + i);
      check_eq("tp_ready", in_ready, 1);
    end
    in_valid = 0;
    step();
    check_eq("tp_count", op_count, 15);
    check_eq("tp_count_sat", s_op_count, 15);

    // reset mid-operation with both entries full
    out_ready = 0; in_valid = 1; in_r = 16'h1111; in_flags = 6'b001000; in_tag = 4'd5;
    step();
    in_r = 16'h2222; in_flags = 6'b000000;
    step();
    check_eq("mr_full", in_ready, 0);
    check_eq("mr_sticky", sticky_flags, 4'b1000);
    in_valid = 0;
    #2 rst = 1;
    #1;
    check_eq("mr_out_valid", out_valid, 0);
    check_eq("mr_in_ready", in_ready, 1);
    check_eq("mr_sticky_clr", sticky_flags, 0);
    check_eq("mr_count", op_count, 0);
    check_eq("mr_out_r", out_r, 0);
    step();
    rst = 0;
    in_valid = 1; in_r = 16'hABCD; in_tag = 4'd6; out_ready = 1;
    step();
    check_eq("mr_next_valid", out_valid, 1);
    check_eq("mr_next_r", out_r, 16'hABCD);
    check_eq("mr_next_tag", out_tag, 6);
    check_eq("mr_next_count", op_count, 1);

    // counter saturation (4-bit instance), 20 more accepts
    for (int i = 1; i <= 20; i++) begin
      in_r = 16'(i);
      step();
      check_eq("sat_count4", s_op_count, (1 + i > 15) ? 15 : 1 + i);
    end
    in_valid = 0;
    step();
    check_eq("sat_final4", s_op_count, 15);
    check_eq("sat_final8", op_count, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
